// File: rtl/sys_arith_seq_sum.sv
// sys_arith_seq_sum: iterative arithmetic-series sum, one term per clock, with
// valid/ready request and result handshakes and a sticky overflow flag.
module sys_arith_seq_sum #(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_first,
  input  logic [W-1:0]  s_diff,
  input  logic [NW-1:0] s_num,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_sum,
  output logic          m_ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_nx;
  logic [W-1:0]  acc, term, diff;
  logic [NW-1:0] cnt;
  logic          ovf;
  logic [W:0]    acc_sum, term_sum;
  assign acc_sum  = {1'b0, acc} + {1'b0, term};
  assign term_sum = {1'b0, term} + {1'b0, diff};
  always_comb begin
    state_nx = state == IDLE ? (s_valid ? (s_num == '0 ? DONE : RUN) : IDLE) :
               state == RUN  ? (cnt == NW'(1) ? DONE : RUN) :
               (m_ready ? IDLE : DONE);
  end
  // A term wrap on the final edge is never added, so it cannot affect the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      term  <= '0;
      diff  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && s_valid) begin
        acc  <= '0;
        term <= s_first;
        diff <= s_diff;
        cnt  <= s_num;
        ovf  <= 1'b0;
      end else if (state == RUN) begin
        acc  <= acc_sum[W-1:0];
        term <= term_sum[W-1:0];
        cnt  <= cnt - NW'(1);
        ovf  <= ovf | acc_sum[W] | (term_sum[W] && cnt > NW'(1));
      end
    end
  end
  assign s_ready = state == IDLE;
  assign m_valid = state == DONE;
  assign m_sum   = acc;
  assign m_ovf   = ovf;
endmodule

// File: tb/tb_sys_arith_seq_sum.sv
// tb_sys_arith_seq_sum: scoreboard bench; expected sums come from the closed-form
// series formula, a separate monitor checks results, latency and hold stability.
module tb_sys_arith_seq_sum;
  localparam int W  = 8;
  localparam int NW = 8;
  logic          clk = 0, rst_n = 0, s_valid = 0, m_ready = 0;
  logic [W-1:0]  s_first = 0, s_diff = 0;
  logic [NW-1:0] s_num = 0;
  logic          s_ready, m_valid, m_ovf;
  logic [W-1:0]  m_sum;
  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
    int           lat;
  } exp_t;
  exp_t         sb[$];
  int           errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
  bit           hold = 0, have = 0;
  logic [W-1:0] held_sum;
  logic         held_ovf;

  sys_arith_seq_sum #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_first(s_first), .s_diff(s_diff), .s_num(s_num),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_ovf(m_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sum of n terms = n*a0 + d*n(n-1)/2, evaluated without any wrap.
  function automatic exp_t model(input int unsigned a, input int unsigned d, input int unsigned n);
    longint unsigned t;
    exp_t e;
    t = longint'(n) * a + longint'(d) * n * (n - (n > 0 ? 1 : 0)) / 2;
    e.sum = W'(t);
    e.ovf = t >= (64'd1 << W);
    e.lat = n == 0 ? 1 : n + 1;
    return e;
  endfunction

  task automatic send(input int unsigned a, input int unsigned d, input int unsigned n);
    exp_t e;
    int t = 0;
    e = model(a, d, n);
    @(posedge clk);
    #1;
    s_first = W'(a);
    s_diff  = W'(d);
    s_num   = NW'(n);
    s_valid = 1;
    @(negedge clk);
    while (!s_ready && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (!s_ready) check("accept_timeout", 0, 1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
    s_valid = 0;
    s_first = W'($urandom);
    s_diff  = W'($urandom);
    s_num   = NW'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || m_valid) && t < 5000) begin
      t++;
      @(negedge clk);
    end
    if (t >= 5000) check("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) have = 0;
    else begin
      if (s_valid && s_ready) acc_cyc = cyc;
      if (m_valid) begin
        if (!have) begin
          if (sb.size() == 0) check("unexpected_valid", 1, 0);
          else begin
            e = sb.pop_front();
            check("sum", m_sum, e.sum);
            check("ovf", m_ovf, e.ovf);
            check("latency", cyc - acc_cyc, e.lat);
            held_sum = m_sum;
            held_ovf = m_ovf;
            have = 1;
          end
        end else begin
          check("hold_sum", m_sum, held_sum);
          check("hold_ovf", m_ovf, held_ovf);
        end
        if (m_ready) have = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_sum", m_sum, 0);
    check("rst_m_ovf", m_ovf, 0);
    #11 rst_n = 1;
    send(1, 1, 4);
    send(7, 3, 0);
    send(200, 10, 2);
    send(100, 200, 1);
    send(100, 200, 2);
    send(10, 255, 5);
    send(5, 0, 3);
    send(3, 1, 255);
    drain();
    for (int i = 0; i < 30; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 12));
    drain();
    hold = 1;
    send(2, 2, 3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      s_valid = 1'($urandom_range(0, 1));
      s_first = W'($urandom);
      s_diff  = W'($urandom);
      s_num   = NW'($urandom_range(0, 5));
    end
    s_valid = 0;
    @(negedge clk);
    check("bp_m_valid", m_valid, 1);
    check("bp_s_ready", s_ready, 0);
    check("bp_m_sum", m_sum, 12);
    hold = 0;
    drain();
    send(9, 1, 100);
    repeat (20) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("abort_s_ready", s_ready, 1);
    check("abort_m_valid", m_valid, 0);
    check("abort_m_sum", m_sum, 0);
    check("abort_m_ovf", m_ovf, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    send(5, 0, 3);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
